// File: rtl/csr_unit_pkg.sv
// Shared definitions for csr_unit: CSR addresses, mcause codes, mstatus bit positions
// and the command encoding decoded from the csr_write/set/clear strobes.
package csr_unit_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam logic [3:0] MCAUSE_INST_MISALIGNED  = 4'd0;
    localparam logic [3:0] MCAUSE_ILLEGAL          = 4'd2;
    localparam logic [3:0] MCAUSE_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] MCAUSE_STORE_MISALIGNED = 4'd6;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    typedef enum logic [1:0] {
        CSR_CMD_NONE  = 2'd0,
        CSR_CMD_WRITE = 2'd1,
        CSR_CMD_SET   = 2'd2,
        CSR_CMD_CLEAR = 2'd3
    } csr_cmd_e;

    function automatic logic [31:0] csr_apply(input csr_cmd_e cmd, input logic [31:0] old_val,
                                              input logic [31:0] op);
        case (cmd)
            CSR_CMD_WRITE: return op;
            CSR_CMD_SET:   return old_val | op;
            CSR_CMD_CLEAR: return old_val & ~op;
            default:       return old_val;
        endcase
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with per-half software write ports; a write in
// either half drops that cycle's increment and never carries across halves.
module csr_counter64 (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] value_o
);

    logic [63:0] cnt_q;
    logic [63:0] cnt_d;

    // Next count: software write beats increment
    always_comb begin
        cnt_d = cnt_q;
        if (wr_lo_i) begin
            cnt_d[31:0] = wdata_i;
        end else if (wr_hi_i) begin
            cnt_d[63:32] = wdata_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + 64'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 64'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value_o = cnt_q;

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file and trap controller for the RV32I core.
// Define CSR_COUNTERS_EN to implement mcycle/minstret; otherwise they read 0.
module csr_unit
    import csr_unit_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0010,
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] csr_addr,
    input  logic        csr_read,
    input  logic        csr_write,
    input  logic        csr_set,
    input  logic        csr_clear,
    input  logic        csr_imm,
    input  logic [4:0]  rs1_field,
    input  logic [31:0] rs1_data,
    input  logic        retire,
    input  logic        exc_inst_misaligned,
    input  logic        exc_illegal,
    input  logic        exc_unsupported,
    input  logic        exc_mem_misaligned,
    input  logic        mem_is_store,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_value,
    input  logic        mret,
    output logic [31:0] csr_rdata,
    output logic        trap_taken,
    output logic        csr_illegal,
    output logic [31:0] mtvec_out,
    output logic [31:0] mepc_out,
    output logic        mie_out
);

    logic        mie_q, mie_d, mpie_q, mpie_d;
    logic [31:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
    logic [63:0] mcycle, minstret;
    logic [31:0] mstatus_val, cur_val, new_val, operand;
    logic        addr_valid, addr_ro, cmd_any, wr_intent, wr_en, exc_any, trap_req;
    logic [3:0]  trap_cause;
    csr_cmd_e    cmd;

    // mstatus view: MPP hardwired to machine mode
    always_comb begin
        mstatus_val = 32'd0;
        mstatus_val[MSTATUS_MIE] = mie_q;
        mstatus_val[MSTATUS_MPIE] = mpie_q;
        mstatus_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end

    // Address decode and current-value mux
    always_comb begin
        addr_valid = 1'b1;
        case (csr_addr)
            CSR_MSTATUS:                 cur_val = mstatus_val;
            CSR_MISA:                    cur_val = MISA_VALUE;
            CSR_MTVEC:                   cur_val = mtvec_q;
            CSR_MSCRATCH:                cur_val = mscratch_q;
            CSR_MEPC:                    cur_val = mepc_q;
            CSR_MCAUSE:                  cur_val = mcause_q;
            CSR_MTVAL:                   cur_val = mtval_q;
            CSR_MCYCLE, CSR_CYCLE:       cur_val = mcycle[31:0];
            CSR_MCYCLEH, CSR_CYCLEH:     cur_val = mcycle[63:32];
            CSR_MINSTRET, CSR_INSTRET:   cur_val = minstret[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: cur_val = minstret[63:32];
            CSR_MHARTID:                 cur_val = HART_ID;
            default: begin
                addr_valid = 1'b0;
                cur_val    = 32'd0;
            end
        endcase
    end

    // Command decode; set/clear with x0/zimm=0 are pure reads
    always_comb begin
        if (csr_write) begin
            cmd = CSR_CMD_WRITE;
        end else if (csr_set && (rs1_field != 5'd0)) begin
            cmd = CSR_CMD_SET;
        end else if (csr_clear && (rs1_field != 5'd0)) begin
            cmd = CSR_CMD_CLEAR;
        end else begin
            cmd = CSR_CMD_NONE;
        end
    end

    assign operand     = csr_imm ? {27'd0, rs1_field} : rs1_data;
    assign new_val     = csr_apply(cmd, cur_val, operand);
    assign cmd_any     = csr_read | csr_write | csr_set | csr_clear;
    assign wr_intent   = (cmd != CSR_CMD_NONE);
    assign addr_ro     = (csr_addr[11:10] == 2'b11) || (csr_addr == CSR_MISA);
    assign csr_illegal = ~reset & cmd_any & (~addr_valid | (wr_intent & addr_ro));
    assign exc_any     = exc_inst_misaligned | exc_illegal | exc_unsupported | exc_mem_misaligned;
    assign trap_req    = exc_any | csr_illegal;
    assign trap_taken  = trap_req & ~reset;
    assign wr_en       = wr_intent & ~trap_req;
    assign csr_rdata   = csr_read ? cur_val : 32'd0;

    // Trap cause priority
    always_comb begin
        if (exc_inst_misaligned) begin
            trap_cause = MCAUSE_INST_MISALIGNED;
        end else if (exc_illegal || exc_unsupported || csr_illegal) begin
            trap_cause = MCAUSE_ILLEGAL;
        end else if (mem_is_store) begin
            trap_cause = MCAUSE_STORE_MISALIGNED;
        end else begin
            trap_cause = MCAUSE_LOAD_MISALIGNED;
        end
    end

    // Next state: trap entry beats MRET beats software write
    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        if (trap_req) begin
            mepc_d   = trap_pc & ~32'd3;
            mcause_d = {28'd0, trap_cause};
            mtval_d  = trap_value;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (mret) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end else if (wr_en) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mie_d  = new_val[MSTATUS_MIE];
                    mpie_d = new_val[MSTATUS_MPIE];
                end
                CSR_MTVEC:    mtvec_d    = new_val & ~32'd3;
                CSR_MSCRATCH: mscratch_d = new_val;
                CSR_MEPC:     mepc_d     = new_val & ~32'd3;
                CSR_MCAUSE:   mcause_d   = {new_val[31], 27'd0, new_val[3:0]};
                CSR_MTVAL:    mtval_d    = new_val;
                default:      mtval_d    = mtval_q;
            endcase
        end else begin
            mtval_d = mtval_q;
        end
    end

    // CSR state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= MTVEC_RESET & ~32'd3;
            mscratch_q <= 32'd0;
            mepc_q     <= 32'd0;
            mcause_q   <= 32'd0;
            mtval_q    <= 32'd0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
        end
    end

`ifdef CSR_COUNTERS_EN
    csr_counter64 u_mcycle (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (1'b1),
        .wr_lo_i (wr_en && (csr_addr == CSR_MCYCLE)),
        .wr_hi_i (wr_en && (csr_addr == CSR_MCYCLEH)),
        .wdata_i (new_val),
        .value_o (mcycle)
    );

    csr_counter64 u_minstret (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (retire & ~trap_taken),
        .wr_lo_i (wr_en && (csr_addr == CSR_MINSTRET)),
        .wr_hi_i (wr_en && (csr_addr == CSR_MINSTRETH)),
        .wdata_i (new_val),
        .value_o (minstret)
    );
`else
    logic unused_retire;
    assign unused_retire = retire;
    assign mcycle        = 64'd0;
    assign minstret      = 64'd0;
`endif

    assign mtvec_out = mtvec_q;
    assign mepc_out  = mepc_q;
    assign mie_out   = mie_q;

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: expectations are queued with each stimulus step and
// drained against the DUT outputs on the falling edge before the commit edge.
module tb_csr_unit;

`ifdef CSR_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam int SEL_RDATA = 0;
    localparam int SEL_TRAP  = 1;
    localparam int SEL_ILL   = 2;
    localparam int SEL_MTVEC = 3;
    localparam int SEL_MEPC  = 4;
    localparam int SEL_MIE   = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] csr_addr;
    logic        csr_read, csr_write, csr_set, csr_clear, csr_imm;
    logic [4:0]  rs1_field;
    logic [31:0] rs1_data;
    logic        retire;
    logic        exc_inst_misaligned, exc_illegal, exc_unsupported, exc_mem_misaligned;
    logic        mem_is_store;
    logic [31:0] trap_pc, trap_value;
    logic        mret;
    logic [31:0] csr_rdata;
    logic        trap_taken, csr_illegal;
    logic [31:0] mtvec_out, mepc_out;
    logic        mie_out;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    csr_unit #(
        .MTVEC_RESET (32'h0000_0010),
        .HART_ID     (32'h0000_0005),
        .MISA_VALUE  (32'h4000_0100)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .csr_addr            (csr_addr),
        .csr_read            (csr_read),
        .csr_write           (csr_write),
        .csr_set             (csr_set),
        .csr_clear           (csr_clear),
        .csr_imm             (csr_imm),
        .rs1_field           (rs1_field),
        .rs1_data            (rs1_data),
        .retire              (retire),
        .exc_inst_misaligned (exc_inst_misaligned),
        .exc_illegal         (exc_illegal),
        .exc_unsupported     (exc_unsupported),
        .exc_mem_misaligned  (exc_mem_misaligned),
        .mem_is_store        (mem_is_store),
        .trap_pc             (trap_pc),
        .trap_value          (trap_value),
        .mret                (mret),
        .csr_rdata           (csr_rdata),
        .trap_taken          (trap_taken),
        .csr_illegal         (csr_illegal),
        .mtvec_out           (mtvec_out),
        .mepc_out            (mepc_out),
        .mie_out             (mie_out)
    );

    function automatic logic [31:0] cexp(input logic [31:0] v);
        return CNT_EN ? v : 32'd0;
    endfunction

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SEL_RDATA: return csr_rdata;
            SEL_TRAP:  return {31'd0, trap_taken};
            SEL_ILL:   return {31'd0, csr_illegal};
            SEL_MTVEC: return mtvec_out;
            SEL_MEPC:  return mepc_out;
            SEL_MIE:   return {31'd0, mie_out};
            default:   return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic clear_inputs();
        reset = 1'b0; csr_addr = 12'h000;
        csr_read = 1'b0; csr_write = 1'b0; csr_set = 1'b0; csr_clear = 1'b0; csr_imm = 1'b0;
        rs1_field = 5'd0; rs1_data = 32'd0; retire = 1'b0;
        exc_inst_misaligned = 1'b0; exc_illegal = 1'b0; exc_unsupported = 1'b0;
        exc_mem_misaligned = 1'b0; mem_is_store = 1'b0;
        trap_pc = 32'd0; trap_value = 32'd0; mret = 1'b0;
    endtask

    task automatic want(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb_q.push_back(e);
    endtask

    // Drain the scoreboard on the falling edge, then let the rising edge commit.
    task automatic tick();
        exp_t        e;
        logic [31:0] obs;
        @(negedge clk);
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            obs = observe(e.sel);
            checks++;
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed %h expected %h", e.tag, obs, e.val);
            end
        end
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic csr_cmd(input logic [11:0] a, input logic r, input logic w, input logic s,
                           input logic c, input logic i, input logic [4:0] f, input logic [31:0] d);
        csr_addr = a; csr_read = r; csr_write = w; csr_set = s; csr_clear = c;
        csr_imm = i; rs1_field = f; rs1_data = d;
    endtask

    task automatic rd(input logic [11:0] a, input string tag, input logic [31:0] val);
        csr_cmd(a, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        want(tag, SEL_RDATA, val);
        tick();
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr_cmd(a, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, d);
        tick();
    endtask

    initial begin
        clear_inputs();
        // Reset with a trap and an illegal access pending
        reset = 1'b1; exc_illegal = 1'b1; csr_cmd(12'h7C0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        want("rst_trap", SEL_TRAP, 32'd0);
        want("rst_ill", SEL_ILL, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        want("rst_mtvec_out", SEL_MTVEC, 32'h10);
        want("rst_mie", SEL_MIE, 32'd0);
        want("rst_mepc_out", SEL_MEPC, 32'd0);
        rd(12'h305, "rst_mtvec", 32'h0000_0010);
        rd(12'h300, "rst_mstatus", 32'h0000_1800);
        rd(12'h301, "misa", 32'h4000_0100);

        // mcycle counts ten idle cycles after being cleared
        wr(12'hB00, 32'd0);
        repeat (10) tick();
        rd(12'hB00, "mcycle_10", cexp(32'd10));
        rd(12'hC00, "cycle_shadow", cexp(32'd11));
        rd(12'hB80, "mcycleh_0", 32'd0);

        // minstret: write drops same-cycle retire; trapped retire not counted
        retire = 1'b1; csr_cmd(12'hB02, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 32'd0);
        want("minstret_wr_ill", SEL_ILL, 32'd0);
        tick();
        repeat (3) begin retire = 1'b1; tick(); end
        retire = 1'b1; exc_illegal = 1'b1; trap_pc = 32'h40;
        want("retire_trap", SEL_TRAP, 32'd1);
        tick();
        rd(12'hC02, "instret_3", cexp(32'd3));
        want("mepc_40", SEL_MEPC, 32'h40);
        rd(12'h342, "mcause_exc_ill", 32'd2);

        // mscratch read/write/clear/set
        csr_cmd(12'h340, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'hDEAD_BEEF);
        want("csrrw_old", SEL_RDATA, 32'd0);
        want("csrrw_trap", SEL_TRAP, 32'd0);
        tick();
        rd(12'h340, "mscratch_w", 32'hDEAD_BEEF);
        csr_cmd(12'h340, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'h0F, 32'hFFFF_FFFF);
        want("csrrci_old", SEL_RDATA, 32'hDEAD_BEEF);
        tick();
        rd(12'h340, "mscratch_c", 32'hDEAD_BEE0);
        csr_cmd(12'h340, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd2, 32'h1);
        tick();
        csr_cmd(12'h340, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF);
        tick();
        rd(12'h340, "mscratch_s", 32'hDEAD_BEE1);

        // mhartid: read-only, set with x0 legal, set with rs1!=0 illegal
        csr_cmd(12'hF14, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'hFFFF_FFFF);
        want("hartid_rd", SEL_RDATA, 32'h5);
        want("hartid_ill0", SEL_ILL, 32'd0);
        want("hartid_trap0", SEL_TRAP, 32'd0);
        tick();
        csr_cmd(12'hF14, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 32'hFFFF_FFFF);
        trap_pc = 32'h203; trap_value = 32'hF140_2573;
        want("hartid_ill1", SEL_ILL, 32'd1);
        want("hartid_trap1", SEL_TRAP, 32'd1);
        tick();
        want("hartid_mepc", SEL_MEPC, 32'h200);
        rd(12'h342, "hartid_mcause", 32'd2);
        rd(12'h343, "hartid_mtval", 32'hF140_2573);
        rd(12'hF14, "hartid_keep", 32'h5);

        // Unimplemented address, misa write, legal shadow read
        csr_cmd(12'h7C0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        want("unimpl_ill", SEL_ILL, 32'd1);
        want("unimpl_rd", SEL_RDATA, 32'd0);
        tick();
        csr_cmd(12'h301, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 32'd0);
        want("misa_wr_ill", SEL_ILL, 32'd1);
        tick();
        csr_cmd(12'hC00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        want("shadow_ro_rd", SEL_ILL, 32'd0);
        tick();

        // Write legalisation
        wr(12'h305, 32'h0000_0203);
        want("mtvec_legal_out", SEL_MTVEC, 32'h200);
        rd(12'h305, "mtvec_legal", 32'h0000_0200);
        wr(12'h342, 32'hFFFF_FFFF);
        rd(12'h342, "mcause_legal", 32'h8000_000F);
        wr(12'h341, 32'h0000_0107);
        want("mepc_legal", SEL_MEPC, 32'h104);
        csr_cmd(12'h300, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd8, 32'd0);
        tick();
        want("mie_set", SEL_MIE, 32'd1);
        rd(12'h300, "mstatus_mie", 32'h0000_1808);

        // Store-misaligned trap with a suppressed same-cycle CSR write
        exc_mem_misaligned = 1'b1; mem_is_store = 1'b1; trap_pc = 32'h104; trap_value = 32'h203;
        csr_cmd(12'h340, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 32'h1234);
        want("st_trap", SEL_TRAP, 32'd1);
        want("st_ill", SEL_ILL, 32'd0);
        tick();
        want("st_mepc", SEL_MEPC, 32'h104);
        want("st_mie", SEL_MIE, 32'd0);
        rd(12'h342, "st_mcause", 32'd6);
        rd(12'h343, "st_mtval", 32'h203);
        rd(12'h300, "st_mstatus", 32'h0000_1880);
        rd(12'h340, "st_no_write", 32'hDEAD_BEE1);

        // MRET restores MIE
        mret = 1'b1;
        want("mret_trap", SEL_TRAP, 32'd0);
        tick();
        want("mret_mie", SEL_MIE, 32'd1);
        want("mret_mepc", SEL_MEPC, 32'h104);
        rd(12'h300, "mret_mstatus", 32'h0000_1888);

        // Load-misaligned, then priority and trap-over-MRET
        exc_mem_misaligned = 1'b1; trap_pc = 32'h10B;
        tick();
        want("ld_mepc", SEL_MEPC, 32'h108);
        rd(12'h342, "ld_mcause", 32'd4);
        rd(12'h300, "ld_mstatus", 32'h0000_1880);
        exc_inst_misaligned = 1'b1; exc_illegal = 1'b1; exc_mem_misaligned = 1'b1;
        mret = 1'b1; trap_pc = 32'h300;
        tick();
        rd(12'h342, "prio_mcause", 32'd0);
        want("prio_mie", SEL_MIE, 32'd0);
        rd(12'h300, "prio_mstatus", 32'h0000_1800);

        // Counter wrap, hi write drops increment, lo overflow carries
        wr(12'hB00, 32'hFFFF_FFFF);
        wr(12'hB80, 32'hFFFF_FFFF);
        rd(12'hB80, "mcycleh_ones", cexp(32'hFFFF_FFFF));
        rd(12'hB00, "mcycle_wrap_lo", 32'd0);
        rd(12'hB80, "mcycle_wrap_hi", 32'd0);
        wr(12'hB00, 32'h10);
        csr_cmd(12'hB80, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 32'h5);
        want("mcycleh_old", SEL_RDATA, 32'd0);
        tick();
        rd(12'hB00, "mcycle_hold", cexp(32'h10));
        rd(12'hB80, "mcycleh_5", cexp(32'h5));
        wr(12'hB02, 32'hFFFF_FFFF);
        retire = 1'b1;
        tick();
        rd(12'hB82, "minstreth_carry", cexp(32'd1));
        rd(12'hB02, "minstret_lo0", 32'd0);

        // Reset overrides a same-cycle write and trap
        reset = 1'b1; exc_illegal = 1'b1;
        csr_cmd(12'h305, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 32'h80);
        want("rst2_trap", SEL_TRAP, 32'd0);
        want("rst2_ill", SEL_ILL, 32'd0);
        tick();
        rd(12'hB00, "rst2_mcycle", 32'd0);
        want("rst2_mtvec", SEL_MTVEC, 32'h10);
        want("rst2_mepc", SEL_MEPC, 32'd0);
        rd(12'h342, "rst2_mcause", 32'd0);
        rd(12'h340, "rst2_mscratch", 32'd0);
        rd(12'h300, "rst2_mstatus", 32'h0000_1800);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
